mdc_commutator: RTL and testbench

Delay-commutator stage of the multipath delay-commutator (MDC) radix-2 FFT pipeline. It sits directly upstream of a butterfly and reorders two parallel complex sample streams so that the butterfly receives pairs of samples spaced DEPTH apart in the same stream. It also produces the trivial-twiddle select (×1 / ×(−j)) for the downstream butterfly's `twd` input, aligned with each output pair.

---
 rtl/mdc_commutator.sv | 88 ++++++++
 tb/tb_mdc_commutator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdc_commutator.sv
// Delay-commutator stage of an MDC radix-2 FFT: delays and swaps two complex
// streams so the following butterfly sees pairs DEPTH apart, plus its twiddle select.
module mdc_commutator #(
  parameter int NBITS = 10,
  parameter int DEPTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [2*NBITS-1:0] din_up,
  input  logic [2*NBITS-1:0] din_down,
  output logic               out_valid,
  output logic [2*NBITS-1:0] dout_up,
  output logic [2*NBITS-1:0] dout_down,
  output logic               twd
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = 2 * NBITS;

  // Handshake: in_valid qualifies din_* for one cycle with no backpressure;
  // out_valid is a one-cycle strobe marking a fresh pair on dout_*/twd, and
  // the outputs hold their last pair while out_valid is low.

  logic [W-1:0]  line_a [DEPTH];
  logic [W-1:0]  line_b [DEPTH];
  logic [CW-1:0] icnt;
  logic [CW-1:0] ocnt;
  logic          fill;
  logic          s;
  logic [W-1:0]  a_d;
  logic [W-1:0]  b_d;
  logic [W-1:0]  top;
  logic [W-1:0]  bot_pre;

  assign s   = icnt[CW-1];
  assign a_d = line_a[DEPTH-1];
  assign b_d = line_b[DEPTH-1];

  always_comb begin
    top     = a_d;
    bot_pre = din_down;
    if (s) begin
      top     = din_down;
      bot_pre = a_d;
    end
  end

  // Storage is left unreset: anything stale is masked until fill is set.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      line_a[0] <= din_up;
      line_b[0] <= bot_pre;
      for (int i = 1; i < DEPTH; i++) begin
        line_a[i] <= line_a[i-1];
        line_b[i] <= line_b[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      icnt      <= '0;
      ocnt      <= '0;
      fill      <= 1'b0;
      out_valid <= 1'b0;
      dout_up   <= '0;
      dout_down <= '0;
      twd       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        icnt <= icnt + CW'(1);
        if (icnt == CW'(DEPTH - 1)) begin
          fill <= 1'b1;
        end
        if (fill) begin
          out_valid <= 1'b1;
          dout_up   <= top;
          dout_down <= b_d;
          twd       <= ~ocnt[CW-1];
          ocnt      <= ocnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mdc_commutator.sv
// Bench for mdc_commutator: three instances (DEPTH 2, 1, 32) driven by directed
// streams, with a queue-based scoreboard and a free-running output monitor.
module tb_mdc_commutator;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv [3];
  logic [19:0] du [3];
  logic [19:0] dd [3];
  logic        ov [3];
  logic [19:0] ou [3];
  logic [19:0] od [3];
  logic        tw [3];

  logic [40:0] exp_q0[$];
  logic [40:0] exp_q1[$];
  logic [40:0] exp_q2[$];
  logic [40:0] last_exp [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdc_commutator #(.NBITS(10), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .din_up(du[0]), .din_down(dd[0]),
    .out_valid(ov[0]), .dout_up(ou[0]), .dout_down(od[0]), .twd(tw[0]));

  mdc_commutator #(.NBITS(10), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .din_up(du[1]), .din_down(dd[1]),
    .out_valid(ov[1]), .dout_up(ou[1]), .dout_down(od[1]), .twd(tw[1]));

  mdc_commutator #(.NBITS(10), .DEPTH(32)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .din_up(du[2]), .din_down(dd[2]),
    .out_valid(ov[2]), .dout_up(ou[2]), .dout_down(od[2]), .twd(tw[2]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int depth_of(input int idx);
    return (idx == 0) ? 2 : (idx == 1) ? 1 : 32;
  endfunction

  // Sample k of a stream; the DEPTH-32 instance gets full-scale 0x1FF/0x200 parts.
  function automatic logic [19:0] stim(input int idx, input bit upper, input int k);
    logic [9:0] v;
    if (idx == 2) begin
      v = 10'(k);
      if (upper) return {((k % 2) == 1) ? 10'h1FF : 10'h200, v};
      return {(((k / 2) % 2) == 1) ? 10'h200 : 10'h1FF, ~v};
    end
    v = upper ? 10'(k) : 10'(16 + k);
    return {v, v};
  endfunction

  // Output m: groups of 2*D pairs, first D from the lower stream (twd=1),
  // then D from the upper stream (twd=0); each pair is (x[n+D], x[n]).
  function automatic logic [40:0] exp_pair(input int idx, input int m);
    int d, g, r, n;
    d = depth_of(idx);
    g = m / (2 * d);
    r = m % (2 * d);
    if (r < d) begin
      n = 2 * d * g + r;
      return {1'b1, stim(idx, 1'b0, n + d), stim(idx, 1'b0, n)};
    end
    n = 2 * d * g + r - d;
    return {1'b0, stim(idx, 1'b1, n + d), stim(idx, 1'b1, n)};
  endfunction

  task automatic send(input int idx, input int k);
    logic [40:0] e;
    @(negedge clk);
    iv[idx] = 1'b1;
    du[idx] = stim(idx, 1'b1, k);
    dd[idx] = stim(idx, 1'b0, k);
    if (k >= depth_of(idx)) begin
      e = exp_pair(idx, k - depth_of(idx));
      last_exp[idx] = e;
      case (idx)
        0: exp_q0.push_back(e);
        1: exp_q1.push_back(e);
        default: exp_q2.push_back(e);
      endcase
    end
  endtask

  task automatic zero_chk(input int idx);
    chk("rst_valid", 64'(ov[idx]), 64'd0);
    chk("rst_outputs", 64'({tw[idx], ou[idx], od[idx]}), 64'd0);
  endtask

  task automatic hold_chk(input int idx);
    chk("gap_valid", 64'(ov[idx]), 64'd0);
    chk("gap_hold", 64'({tw[idx], ou[idx], od[idx]}), 64'(last_exp[idx]));
  endtask

  task automatic gap(input int idx);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) hold_chk(idx);
      iv[idx] = 1'b0;
    end
  endtask

  task automatic finish_stream(input int idx);
    int left;
    @(negedge clk);
    iv[idx] = 1'b0;
    repeat (2) @(negedge clk);
    left = (idx == 0) ? exp_q0.size() : (idx == 1) ? exp_q1.size() : exp_q2.size();
    chk("leftover_pairs", 64'(left), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) iv[i] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) last_exp[i] = '0;
  endtask

  always @(negedge clk) begin
    logic [40:0] e;
    if (ov[0]) begin
      if (exp_q0.size() == 0) chk("d2_extra_valid", 64'(ov[0]), 64'd0);
      else begin
        e = exp_q0.pop_front();
        chk("d2_pair", 64'({tw[0], ou[0], od[0]}), 64'(e));
      end
    end
    if (ov[1]) begin
      if (exp_q1.size() == 0) chk("d1_extra_valid", 64'(ov[1]), 64'd0);
      else begin
        e = exp_q1.pop_front();
        chk("d1_pair", 64'({tw[1], ou[1], od[1]}), 64'(e));
      end
    end
    if (ov[2]) begin
      if (exp_q2.size() == 0) chk("d32_extra_valid", 64'(ov[2]), 64'd0);
      else begin
        e = exp_q2.pop_front();
        chk("d32_pair", 64'({tw[2], ou[2], od[2]}), 64'(e));
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      du[i] = '0;
      dd[i] = '0;
      last_exp[i] = '0;
    end

    // Reset held with live random input.
    iv[0] = 1'b1;
    repeat (3) begin
      du[0] = 20'($urandom);
      dd[0] = 20'($urandom);
      @(negedge clk);
      zero_chk(0);
    end
    rst = 1'b0;
    iv[0] = 1'b0;
    @(negedge clk);
    zero_chk(0);
    zero_chk(1);
    zero_chk(2);

    // DEPTH=2 ordering, continuous input.
    do_reset();
    for (int k = 0; k < 10; k++) send(0, k);
    finish_stream(0);

    // DEPTH=2 ordering with 3-cycle stalls after every second sample.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      send(0, k);
      if ((k % 2) == 1) gap(0);
    end
    finish_stream(0);

    // Mid-run reset, asserted while in_valid is high.
    do_reset();
    for (int k = 0; k < 5; k++) send(0, k);
    @(negedge clk);
    rst = 1'b1;
    iv[0] = 1'b1;
    du[0] = 20'($urandom);
    dd[0] = 20'($urandom);
    @(negedge clk);
    rst = 1'b0;
    iv[0] = 1'b0;
    last_exp[0] = '0;
    zero_chk(0);
    chk("midrst_leftover", 64'(exp_q0.size()), 64'd0);
    for (int k = 0; k < 4; k++) send(0, k);
    finish_stream(0);

    // DEPTH=32 full-scale stream.
    do_reset();
    for (int k = 0; k < 256; k++) send(2, k);
    finish_stream(2);

    // DEPTH=1 edge case.
    do_reset();
    for (int k = 0; k < 6; k++) send(1, k);
    finish_stream(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
